// File: rtl/exc_arbiter.sv
// exc_arbiter: prioritised exception/interrupt arbiter with EPC capture and flush/handler/ERET sequencing
module exc_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int NUM_IRQ   = 6,
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = 2,
  parameter int IRQ_SYNC  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*5-1:0]      src_code,
  input  logic [NUM_SRC*ADDR_W-1:0] src_pc,
  input  logic [NUM_SRC-1:0]        src_bd,
  input  logic [ADDR_W-1:0]         int_pc,
  input  logic                      int_bd,
  input  logic [NUM_IRQ-1:0]        irq_in,
  input  logic [NUM_IRQ-1:0]        irq_mask,
  input  logic                      ie,
  input  logic                      eret,
  output logic                      exc_take,
  output logic [4:0]                exc_code,
  output logic [ADDR_W-1:0]         epc,
  output logic                      bd,
  output logic                      exl,
  output logic [NUM_IRQ-1:0]        ip,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, FLUSH, HANDLER} state_t;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);
  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                w_hit, w_irq, w_take, w_load_epc, w_bd;
  logic [4:0]          w_code;
  logic [ADDR_W-1:0]   w_pc, w_pc_adj, w_epc;
  generate
    if (IRQ_SYNC == 0) begin : g_nosync
      assign ip = irq_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] r_sync [IRQ_SYNC];
      // synchronise the asynchronous interrupt lines through a flop chain
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int k = 0; k < IRQ_SYNC; k++) r_sync[k] <= '0;
        end else begin
          r_sync[0] <= irq_in;
          for (int k = 1; k < IRQ_SYNC; k++) r_sync[k] <= r_sync[k-1];
        end
      assign ip = r_sync[IRQ_SYNC-1];
    end
  endgenerate
  // pick the winner: interrupt (IDLE only) beats the lowest-index request
  always_comb begin
    w_hit  = 1'b0;
    w_code = '0;
    w_pc   = int_pc;
    w_bd   = int_bd;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (src_req[k]) begin
        w_hit  = 1'b1;
        w_code = src_code[5*k +: 5];
        w_pc   = src_pc[ADDR_W*k +: ADDR_W];
        w_bd   = src_bd[k];
      end
    w_irq = (r_state == IDLE) & ie & ~exl & |(ip & irq_mask);
    if (w_irq) begin
      w_code = '0;
      w_pc   = int_pc;
      w_bd   = int_bd;
    end
  end
  // a delay-slot instruction is charged to its branch, and EPC is always word aligned
  assign w_pc_adj = w_bd ? w_pc - ADDR_W'(4) : w_pc;
  assign w_epc    = {w_pc_adj[ADDR_W-1:2], 2'b00};
  // next-state and take decision
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_load_epc = 1'b0;
    case (r_state)
      IDLE:    if (w_irq | w_hit) begin
                 w_next     = FLUSH;
                 w_take     = 1'b1;
                 w_load_epc = 1'b1;
               end
      FLUSH:   w_next = (r_cnt == '0) ? HANDLER : FLUSH;
      HANDLER: if (w_hit) begin
                 w_next = FLUSH;
                 w_take = 1'b1;
               end else if (eret) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // captured Cause/EPC/SR fields and flush counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exc_take <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
      bd       <= 1'b0;
      exl      <= 1'b0;
      r_cnt    <= '0;
    end else begin
      exc_take <= w_take;
      if (w_take) exc_code <= w_code;
      if (w_load_epc) begin
        epc <= w_epc;
        bd  <= w_bd;
      end
      exl   <= w_take ? 1'b1 : (r_state == HANDLER && w_next == IDLE) ? 1'b0 : exl;
      r_cnt <= w_take ? CNT_INIT : (r_state == FLUSH && r_cnt != '0) ? r_cnt - 4'd1 : r_cnt;
    end
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: randomized check of exc_arbiter against a behavioural model
module tb_exc_arbiter;
  localparam int NS = 4, NI = 6, AW = 32, FC = 2, IS = 2;
  logic           clk = 1'b0, rst_n = 1'b0;
  logic [NS-1:0]  src_req = '0, src_bd = '0;
  logic [NS*5-1:0] src_code = '0;
  logic [NS*AW-1:0] src_pc = '0;
  logic [AW-1:0]  int_pc = '0;
  logic           int_bd = 1'b0, ie = 1'b0, eret = 1'b0;
  logic [NI-1:0]  irq_in = '0, irq_mask = '0;
  logic           exc_take, exl, bd, busy;
  logic [4:0]     exc_code;
  logic [AW-1:0]  epc;
  logic [NI-1:0]  ip;
  int n_tests = 0, n_fail = 0;
  exc_arbiter #(.NUM_SRC(NS), .NUM_IRQ(NI), .ADDR_W(AW), .FLUSH_CYC(FC), .IRQ_SYNC(IS)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_code(src_code), .src_pc(src_pc),
    .src_bd(src_bd), .int_pc(int_pc), .int_bd(int_bd), .irq_in(irq_in), .irq_mask(irq_mask),
    .ie(ie), .eret(eret), .exc_take(exc_take), .exc_code(exc_code), .epc(epc), .bd(bd),
    .exl(exl), .ip(ip), .busy(busy));
  always #5 clk = ~clk;
  // model state: handler active flag, remaining flush cycles, irq history (newest first)
  logic          m_exl, m_take, m_bd;
  int            m_left;
  logic [4:0]    m_code;
  logic [AW-1:0] m_epc;
  logic [NI-1:0] hist[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [NI-1:0] m_ip();
    return (hist.size() >= IS) ? hist[IS-1] : '0;
  endfunction
  function automatic logic [AW-1:0] epc_of(input logic [AW-1:0] pc, input logic b);
    return (b ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
  endfunction
  task automatic m_reset();
    m_exl = 0; m_take = 0; m_bd = 0; m_left = 0; m_code = 0; m_epc = 0;
    hist.delete();
  endtask
  task automatic m_step();
    int w;
    w = -1;
    for (int i = 0; i < NS; i++) if (src_req[i] && w < 0) w = i;
    m_take = 0;
    if (!m_exl) begin
      if (ie && |(m_ip() & irq_mask)) begin
        m_take = 1; m_code = 0; m_epc = epc_of(int_pc, int_bd); m_bd = int_bd;
      end else if (w >= 0) begin
        m_take = 1; m_code = src_code[5*w +: 5];
        m_epc = epc_of(src_pc[AW*w +: AW], src_bd[w]); m_bd = src_bd[w];
      end
      if (m_take) begin m_exl = 1; m_left = FC; end
    end else if (m_left > 0) m_left--;
    else if (w >= 0) begin
      m_take = 1; m_code = src_code[5*w +: 5]; m_left = FC;
    end else if (eret) m_exl = 0;
    hist.push_front(irq_in);
    if (hist.size() > 8) void'(hist.pop_back());
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".take"}, 64'(exc_take), 64'(m_take));
    chk({tag, ".code"}, 64'(exc_code), 64'(m_code));
    chk({tag, ".epc"},  64'(epc),      64'(m_epc));
    chk({tag, ".bd"},   64'(bd),       64'(m_bd));
    chk({tag, ".exl"},  64'(exl),      64'(m_exl));
    chk({tag, ".busy"}, 64'(busy),     64'(m_exl));
    chk({tag, ".ip"},   64'(ip),       64'(m_ip()));
  endtask
  task automatic randomize_inputs();
    for (int i = 0; i < NS; i++) begin
      src_req[i]       = ($urandom_range(0, 7) == 0);
      src_code[5*i +: 5] = 5'($urandom());
      src_pc[AW*i +: AW] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom();
      src_bd[i]        = 1'($urandom());
    end
    int_pc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom();
    int_bd = 1'($urandom());
    if ($urandom_range(0, 5) == 0) irq_in = NI'($urandom()) & NI'($urandom());
    irq_mask = NI'($urandom());
    ie   = ($urandom_range(0, 3) != 0);
    eret = 1'($urandom());
  endtask
  initial begin
    m_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      m_step();
      #1;
      check_all("run");
      randomize_inputs();
      if ($urandom_range(0, 99) == 0 || (c % 500 == 250 && m_left > 0)) begin
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        check_all("async_rst");
        #1 rst_n = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
